instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Streaming ARM32 instruction encoder: the inverse of the core's instruction decoder. It turns decoded fields (cond, 7-bit internal opcode, operands) into 32-bit instruction words.
- Words are buffered in a 2-entry output FIFO and tagged with sequential instruction-memory addresses.
- Used by the testbench program loader and the boot-ROM builder to write imem.
- A flush request appends a terminating HALT word and then reports done.

Parameters:
ADDR_W, 10, width of the imem word address counter
BASE_ADDR, 0, address assigned to the first emitted word after reset or clear

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clear  in  1  synchronous restart: empty FIFO, address to BASE_ADDR, clear illegal, state RUN
in_valid  in  1  field bundle valid
in_ready  out  1  encoder accepts bundle this cycle
cond  in  4  condition code
opcode  in  7  internal opcode (decoder encoding)
en_status  in  1  S bit
rn, rd, rs, rm  in  4 each  register fields
shift_op  in  2  shift type
imm5  in  5  shift amount
imm12  in  12  immediate or offset
imm24  in  24  branch offset
P, U, W  in  1 each  memory addressing flags
flush  in  1  request program termination
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer takes head
out_instr  out  32  encoded word
out_addr  out  ADDR_W  imem word address of out_instr
done  out  1  HALT emitted and FIFO drained
illegal  out  1  sticky: an unsupported opcode was seen

Behaviour:
- Reset: FIFO empty, state RUN, counter = BASE_ADDR, illegal = 0.
- Outputs after reset: out_valid = 0, out_instr = 0, out_addr = BASE_ADDR, done = 0, in_ready = 1.
- Priority: rst > clear > normal operation.
- Handshake and latency:
  - Accept when in_valid & in_ready.
  - The encoded word is written into the FIFO at that edge and is visible on out_* the next cycle (latency 1).
  - in_ready = (state==RUN) & (count<2).
  - Pop when out_valid & out_ready. Simultaneous push and pop leave count unchanged.
  - out_instr and out_addr hold stable while out_valid & !out_ready.
- Address counter:
  - Captured into the FIFO entry at push, then incremented.
  - Wraps modulo 2^ADDR_W with no flag.
- Encoding, with D = dp op4 (ADD 0100, SUB 0010, CMP 1010, AND 0000, ORR 1100, EOR 0001, MOV 1101):
  - 0000000 NOP: {cond,0011001,21'b0}.
  - 0000001 HALT: {cond,0001000,21'b0}.
  - Immediate dp (0000100, 0001001–0001101): {cond,001,D,S,rn,rd,imm12}. MOV immediate is not encodable (its opcode is NOP).
  - Register dp (0010000, 0011000–0011101): {cond,000,D,S,rn,rd,imm5,shift_op,0,rm}.
  - Register-shifted dp (0110000, 0111000–0111101): {cond,000,D,S,rn,rd,rs,0,shift_op,1,rm}.
  - BX 1001001: {cond,00010010,FFF,0001,rm}.
  - BLX 1001101: {cond,00010010,FFF,0011,rm}.
  - B 1001000: {cond,1010,imm24}.
  - BL 1001100: {cond,1011,imm24}.
  - LDR literal 1000000: {cond,010,P,U,0,W,1,1111,rd,imm12}.
  - LDR immediate 1100000: {cond,010,P,U,0,W,1,rn,rd,imm12}.
  - LDR register 1101000: {cond,011,P,U,0,W,1,rn,rd,imm5,shift_op,0,rm}.
  - STR immediate 1110000 / STR register 1111000: same as LDR immediate / LDR register with L=0.
  - Any other opcode: emit HALT form with the given cond; set illegal.
- State machine:
  - RUN: if flush, go to HALT_PEND. A bundle accepted in the same cycle is pushed before the HALT.
  - HALT_PEND: in_ready = 0. When count<2, push 32'hE1000000 at the current address and go to DONE.
  - DONE: in_ready = 0; done = (count==0). Stay in DONE until clear or rst. flush is ignored outside RUN.
- clear during HALT_PEND or mid-drain discards all FIFO contents with no pops reported.

Test Plan:
- ADD immediate: cond=E, rn=1, rd=2, imm12=0x005, S=0 -> out_instr 0xE2812005 at out_addr 0, one cycle after accept.
- B / BL / BX / BLX:
  - B cond=0, imm24=0x000010 -> 0x0A000010.
  - BL cond=E, imm24=0x000010 -> 0xEB000010.
  - BX rm=14 -> 0xE12FFF1E.
  - BLX rm=3 -> 0xE12FFF33.
- LDR immediate: P=1, U=1, W=0, rn=3, rd=4, imm12=0x008, cond=E -> 0xE5934008.
  - Same fields as STR immediate -> 0xE5834008.
- Backpressure:
  - Hold out_ready=0 and offer 3 bundles: in_ready drops after 2 accepts, no word lost.
  - Release out_ready: words emerge in order at addresses 0, 1, 2.
- Flush after 3 words: HALT 0xE1000000 at addr 3. done rises the cycle after the last pop; in_ready stays 0 until clear.
- Illegal opcode 7'h7F, cond=E -> 0xE1000000 emitted, illegal=1 sticky until clear.
- Wrap: ADDR_W=2, 5 words -> addresses 0, 1, 2, 3, 0.

Source files
------------

// File: rtl/instr_encoder.sv
// Streaming ARM32 instruction encoder: turns decoded field bundles into instruction words,
// buffers them in a 2-entry FIFO tagged with sequential imem addresses, and appends HALT on flush.
module instr_encoder #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        cond,
   input  logic [6:0]        opcode,
   input  logic              en_status,
   input  logic [3:0]        rn,
   input  logic [3:0]        rd,
   input  logic [3:0]        rs,
   input  logic [3:0]        rm,
   input  logic [1:0]        shift_op,
   input  logic [4:0]        imm5,
   input  logic [11:0]       imm12,
   input  logic [23:0]       imm24,
   input  logic              P,
   input  logic              U,
   input  logic              W,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              done,
   output logic              illegal
);

   typedef enum logic [1:0] {StRun, StHaltPend, StDone} state_e;

   localparam logic [31:0]       HaltWord = 32'hE1000000;
   localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

   state_e            state_q, state_d;
   logic [1:0]        count_q, count_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              illegal_q, illegal_d;
   logic [31:0]       instr_mem_q [2];
   logic [ADDR_W-1:0] addr_mem_q [2];

   logic [3:0]  dp_op;
   logic [31:0] enc_word;
   logic        enc_bad;
   logic        accept, push, pop;
   logic [31:0] push_word;

   // Low nibble of every dp opcode selects the operation; xx0000 is MOV, 0100 is ADD immediate.
   always_comb begin
      dp_op = 4'b0100;
      case (opcode[3:0])
         4'b0000: dp_op = 4'b1101;
         4'b0100: dp_op = 4'b0100;
         4'b1000: dp_op = 4'b0100;
         4'b1001: dp_op = 4'b0010;
         4'b1010: dp_op = 4'b1010;
         4'b1011: dp_op = 4'b0000;
         4'b1100: dp_op = 4'b1100;
         4'b1101: dp_op = 4'b0001;
         default: dp_op = 4'b0100;
      endcase
   end

   always_comb begin
      enc_word = {cond, 7'b0001000, 21'b0};
      enc_bad  = 1'b0;
      case (opcode)
         7'b0000000: enc_word = {cond, 7'b0011001, 21'b0};
         7'b0000001: enc_word = {cond, 7'b0001000, 21'b0};
         7'b0000100, 7'b0001001, 7'b0001010, 7'b0001011, 7'b0001100, 7'b0001101:
            enc_word = {cond, 3'b001, dp_op, en_status, rn, rd, imm12};
         7'b0010000, 7'b0011000, 7'b0011001, 7'b0011010, 7'b0011011, 7'b0011100, 7'b0011101:
            enc_word = {cond, 3'b000, dp_op, en_status, rn, rd, imm5, shift_op, 1'b0, rm};
         7'b0110000, 7'b0111000, 7'b0111001, 7'b0111010, 7'b0111011, 7'b0111100, 7'b0111101:
            enc_word = {cond, 3'b000, dp_op, en_status, rn, rd, rs, 1'b0, shift_op, 1'b1, rm};
         7'b1001001: enc_word = {cond, 8'b00010010, 12'hFFF, 4'b0001, rm};
         7'b1001101: enc_word = {cond, 8'b00010010, 12'hFFF, 4'b0011, rm};
         7'b1001000: enc_word = {cond, 4'b1010, imm24};
         7'b1001100: enc_word = {cond, 4'b1011, imm24};
         7'b1000000: enc_word = {cond, 3'b010, P, U, 1'b0, W, 1'b1, 4'b1111, rd, imm12};
         7'b1100000: enc_word = {cond, 3'b010, P, U, 1'b0, W, 1'b1, rn, rd, imm12};
         7'b1101000:
            enc_word = {cond, 3'b011, P, U, 1'b0, W, 1'b1, rn, rd, imm5, shift_op, 1'b0, rm};
         7'b1110000: enc_word = {cond, 3'b010, P, U, 1'b0, W, 1'b0, rn, rd, imm12};
         7'b1111000:
            enc_word = {cond, 3'b011, P, U, 1'b0, W, 1'b0, rn, rd, imm5, shift_op, 1'b0, rm};
         default: enc_bad = 1'b1;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == StRun) && (count_q != 2'd2);
      accept    = in_valid & in_ready;
      out_valid = (count_q != 2'd0);
      pop       = out_valid & out_ready;
      state_d   = state_q;
      push      = accept;
      push_word = enc_word;
      case (state_q)
         StRun: begin
            if (flush) state_d = StHaltPend;
         end
         StHaltPend: begin
            if (count_q != 2'd2) begin
               push      = 1'b1;
               push_word = HaltWord;
               state_d   = StDone;
            end
         end
         default: ;
      endcase
      count_d   = count_q + {1'b0, push} - {1'b0, pop};
      wr_ptr_d  = wr_ptr_q ^ push;
      rd_ptr_d  = rd_ptr_q ^ pop;
      addr_d    = addr_q + ADDR_W'(push);
      illegal_d = illegal_q | (accept & enc_bad);
      done      = (state_q == StDone) && (count_q == 2'd0);
      illegal   = illegal_q;
      out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
      out_addr  = out_valid ? addr_mem_q[rd_ptr_q] : addr_q;
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_q   <= StRun;
         count_q   <= 2'd0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         addr_q    <= BaseAddr;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         addr_q    <= addr_d;
         illegal_q <= illegal_d;
      end
   end

   // Storage needs no reset: entries are only visible while count_q covers them.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= push_word;
         addr_mem_q[wr_ptr_q]  <= addr_q;
      end
   end

endmodule
